// File: rtl/tx_axis_arb_pkg.sv
// Shared AXIS widths, arbiter state encodings and the legal last-beat TKEEP set
// for the TX stream arbiter and its checker benches.
package tx_axis_arb_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  localparam logic [AXIS_KEEP_W-1:0] TKEEP_FULL = 8'hFF;

  // A final beat must carry a contiguous run of low-order bytes.
  localparam int TKEEP_LAST_N = 8;
  localparam logic [AXIS_KEEP_W-1:0] TKEEP_LAST [TKEEP_LAST_N] = '{
    8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF
  };

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_GRANT0 = 4'b0010,
    ST_GRANT1 = 4'b0100,
    ST_GAP    = 4'b1000
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_P0   = 2'b01,
    GNT_P1   = 2'b10
  } grant_e;

  function automatic logic tkeep_last_ok(input logic [AXIS_KEEP_W-1:0] keep);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < TKEEP_LAST_N; i++) begin
      if (keep == TKEEP_LAST[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/axis_tkeep_chk.sv
// Combinational TKEEP framing check: middle beats must be full, last beats
// must hold a contiguous low-byte mask.
module axis_tkeep_chk
  import tx_axis_arb_pkg::*;
(
  input  logic [AXIS_KEEP_W-1:0] tkeep,
  input  logic                   tlast,
  output logic                   err
);

  assign err = tlast ? ~tkeep_last_ok(tkeep) : (tkeep != TKEEP_FULL);

endmodule

// File: rtl/tx_axis_arb.sv
// Two-requester AXI-Stream arbiter feeding a MAC TX port. Whole packets are
// passed through combinationally; an optional idle gap follows each packet.
module tx_axis_arb
  import tx_axis_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic [AXIS_DATA_W-1:0] s0_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s0_axis_tkeep,
  input  logic                   s0_axis_tvalid,
  input  logic                   s0_axis_tlast,
  input  logic                   s0_axis_tuser,
  output logic                   s0_axis_tready,

  input  logic [AXIS_DATA_W-1:0] s1_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s1_axis_tkeep,
  input  logic                   s1_axis_tvalid,
  input  logic                   s1_axis_tlast,
  input  logic                   s1_axis_tuser,
  output logic                   s1_axis_tready,

  output logic [AXIS_DATA_W-1:0] tx_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] tx_axis_tkeep,
  output logic                   tx_axis_tvalid,
  output logic                   tx_axis_tlast,
  output logic                   tx_axis_tuser,
  input  logic                   tx_axis_tready,

  output logic [63:0]            pkts_fwd0,
  output logic [63:0]            pkts_fwd1,
  output logic [1:0]             cur_grant,
  output logic                   proto_err
);

  // Counter is loaded with GAP_CYCLES-1 so that GAP lasts exactly GAP_CYCLES.
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       proto_err_q;

  logic [1:0] req;
  logic [1:0] granted;
  logic [1:0] pkt_done;
  logic       pick1;
  logic       beat_hs;
  logic       keep_err;

  assign req      = {s1_axis_tvalid, s0_axis_tvalid};
  assign granted  = {state_q == ST_GRANT1, state_q == ST_GRANT0};
  assign beat_hs  = tx_axis_tvalid & tx_axis_tready;
  assign pkt_done = granted & {2{beat_hs & tx_axis_tlast}};

  // Port 1 wins when alone, or on a tie under round-robin after port 0 went last.
  assign pick1 = (req == 2'b10) ||
                 ((req == 2'b11) && (FIXED_PRIO == 0) && !last_grant_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gap_cnt_d    = gap_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) state_d = pick1 ? ST_GRANT1 : ST_GRANT0;
      end
      ST_GRANT0, ST_GRANT1: begin
        if (|pkt_done) begin
          last_grant_d = pkt_done[1];
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) state_d = ST_IDLE;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_axis_tdata  = '0;
    tx_axis_tkeep  = '0;
    tx_axis_tvalid = 1'b0;
    tx_axis_tlast  = 1'b0;
    tx_axis_tuser  = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (granted[0]) begin
      tx_axis_tdata  = s0_axis_tdata;
      tx_axis_tkeep  = s0_axis_tkeep;
      tx_axis_tvalid = s0_axis_tvalid;
      tx_axis_tlast  = s0_axis_tlast;
      tx_axis_tuser  = s0_axis_tuser;
      s0_axis_tready = tx_axis_tready;
    end else if (granted[1]) begin
      tx_axis_tdata  = s1_axis_tdata;
      tx_axis_tkeep  = s1_axis_tkeep;
      tx_axis_tvalid = s1_axis_tvalid;
      tx_axis_tlast  = s1_axis_tlast;
      tx_axis_tuser  = s1_axis_tuser;
      s1_axis_tready = tx_axis_tready;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [63:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)             cnt_q <= '0;
      else if (pkt_done[gi]) cnt_q <= cnt_q + 64'd1;
    end
  end

  assign pkts_fwd0 = g_cnt[0].cnt_q;
  assign pkts_fwd1 = g_cnt[1].cnt_q;

  axis_tkeep_chk u_keep_chk (
    .tkeep (tx_axis_tkeep),
    .tlast (tx_axis_tlast),
    .err   (keep_err)
  );

  // Sticky: only reports framing errors, never blocks the beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    proto_err_q <= 1'b0;
    else if (beat_hs && keep_err) proto_err_q <= 1'b1;
  end

  assign proto_err = proto_err_q;
  assign cur_grant = granted[0] ? GNT_P0 : (granted[1] ? GNT_P1 : GNT_NONE);

endmodule
